// File: rtl/bcd_alu_sequencer_pkg.sv
// rtl/bcd_alu_sequencer_pkg.sv - op codes, FSM states and BCD digit helpers
package bcd_alu_sequencer_pkg;

  localparam int NDIG = 4;

  localparam logic [2:0] SUMA  = 3'd0;
  localparam logic [2:0] RESTA = 3'd1;
  localparam logic [2:0] MULT  = 3'd2;
  localparam logic [2:0] DIV   = 3'd3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDSUB    = 3'd1,
    MUL_SHIFT = 3'd2,
    MUL_ADD   = 3'd3,
    MOD_TRY   = 3'd4,
    DONE      = 3'd5
  } state_e;

  // Returns {carry_out, sum_digit}; non-BCD digits give a defined but meaningless value.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                               input logic cin);
    logic [4:0] t;
    logic [4:0] t_adj;
    t     = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    t_adj = t + 5'd6;
    if (t > 5'd9) return {1'b1, t_adj[3:0]};
    return t;
  endfunction

  function automatic logic [3:0] bcd_nines(input logic [3:0] d);
    return 4'd9 - d;
  endfunction

endpackage

// File: rtl/bcd_alu_sequencer_if.sv
// rtl/bcd_alu_sequencer_if.sv - request/result bundle between calculator FSM and sequencer
interface bcd_alu_sequencer_if;
  logic        start;
  logic [2:0]  op_code;
  logic [15:0] lhs;
  logic [15:0] rhs;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        negative;
  logic        overflow;
  logic        div_by_zero;

  modport master (
    output start, op_code, lhs, rhs,
    input  busy, done, result, negative, overflow, div_by_zero
  );

  modport slave (
    input  start, op_code, lhs, rhs,
    output busy, done, result, negative, overflow, div_by_zero
  );
endinterface

// File: rtl/bcd_addsub_16.sv
// rtl/bcd_addsub_16.sv - combinational 4-digit BCD adder/subtractor
module bcd_addsub_16
  import bcd_alu_sequencer_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] s,
  output logic        carry_or_borrow,
  output logic [15:0] magnitude
);

  logic [15:0] neg;
  logic        c_sum;
  logic        c_neg;
  logic [4:0]  dsum;
  logic [4:0]  dneg;

  // Subtraction is a + nines(b) + 1; a missing carry-out means a < b,
  // and the magnitude is then the ten's complement of the raw sum.
  always_comb begin
    s     = '0;
    neg   = '0;
    c_sum = sub;
    c_neg = 1'b1;
    dsum  = '0;
    dneg  = '0;
    for (int i = 0; i < NDIG; i++) begin
      dsum = bcd_digit_add(a[4*i +: 4], sub ? bcd_nines(b[4*i +: 4]) : b[4*i +: 4], c_sum);
      s[4*i +: 4] = dsum[3:0];
      c_sum = dsum[4];
    end
    for (int i = 0; i < NDIG; i++) begin
      dneg = bcd_digit_add(bcd_nines(s[4*i +: 4]), 4'd0, c_neg);
      neg[4*i +: 4] = dneg[3:0];
      c_neg = dneg[4];
    end
    carry_or_borrow = sub ? ~c_sum : c_sum;
    magnitude       = (sub && !c_sum) ? neg : s;
  end

endmodule

// File: rtl/bcd_alu_sequencer.sv
// rtl/bcd_alu_sequencer.sv - multi-cycle BCD add/sub/mult/remainder sequencer
module bcd_alu_sequencer
  import bcd_alu_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset_in,
  bcd_alu_sequencer_if.slave bus
);

  state_e      state, state_nx;
  logic [2:0]  op_q, op_nx;
  logic [15:0] lhs_q, lhs_nx;
  logic [15:0] rhs_q, rhs_nx;
  logic [15:0] acc, acc_nx;
  logic [1:0]  idx, idx_nx;
  logic [3:0]  count, count_nx;
  logic        busy_q, busy_nx;
  logic        done_q, done_nx;
  logic [15:0] result_q, result_nx;
  logic        negative_q, negative_nx;
  logic        overflow_q, overflow_nx;
  logic        dbz_q, dbz_nx;

  logic [15:0] add_a, add_b, add_s, add_mag;
  logic        add_sub, add_cob;
  logic [3:0]  rhs_digit;
  logic [31:0] trial_wide;
  logic        shifted_out;

  bcd_addsub_16 u_addsub (
    .a               (add_a),
    .b               (add_b),
    .sub             (add_sub),
    .s               (add_s),
    .carry_or_borrow (add_cob),
    .magnitude       (add_mag)
  );

  assign rhs_digit   = rhs_q[{idx, 2'b00} +: 4];
  assign trial_wide  = {16'h0000, rhs_q} << {idx, 2'b00};
  assign shifted_out = |trial_wide[31:16];

  always_comb begin
    add_a   = acc;
    add_b   = lhs_q;
    add_sub = 1'b0;
    case (state)
      ADDSUB: begin
        add_a   = lhs_q;
        add_b   = rhs_q;
        add_sub = (op_q == RESTA);
      end
      MOD_TRY: begin
        add_b   = trial_wide[15:0];
        add_sub = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state      <= IDLE;
      op_q       <= '0;
      lhs_q      <= '0;
      rhs_q      <= '0;
      acc        <= '0;
      idx        <= '0;
      count      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state      <= state_nx;
      op_q       <= op_nx;
      lhs_q      <= lhs_nx;
      rhs_q      <= rhs_nx;
      acc        <= acc_nx;
      idx        <= idx_nx;
      count      <= count_nx;
      busy_q     <= busy_nx;
      done_q     <= done_nx;
      result_q   <= result_nx;
      negative_q <= negative_nx;
      overflow_q <= overflow_nx;
      dbz_q      <= dbz_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    op_nx       = op_q;
    lhs_nx      = lhs_q;
    rhs_nx      = rhs_q;
    acc_nx      = acc;
    idx_nx      = idx;
    count_nx    = count;
    busy_nx     = busy_q;
    done_nx     = 1'b0;
    result_nx   = result_q;
    negative_nx = negative_q;
    overflow_nx = overflow_q;
    dbz_nx      = dbz_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          op_nx       = bus.op_code;
          lhs_nx      = bus.lhs;
          rhs_nx      = bus.rhs;
          acc_nx      = '0;
          idx_nx      = 2'd3;
          count_nx    = '0;
          busy_nx     = 1'b1;
          result_nx   = '0;
          negative_nx = 1'b0;
          overflow_nx = 1'b0;
          dbz_nx      = 1'b0;
          case (bus.op_code)
            SUMA, RESTA: state_nx = ADDSUB;
            MULT:        state_nx = MUL_SHIFT;
            DIV: begin
              if (bus.rhs == 16'h0000) begin
                dbz_nx   = 1'b1;
                state_nx = DONE;
              end else begin
                acc_nx   = bus.lhs;
                state_nx = MOD_TRY;
              end
            end
            default:     state_nx = DONE;
          endcase
        end
      end
      ADDSUB: begin
        acc_nx      = add_mag;
        negative_nx = (op_q == RESTA) && add_cob;
        state_nx    = DONE;
      end
      MUL_SHIFT: begin
        acc_nx = {acc[11:0], 4'h0};
        if (acc[15:12] != 4'h0) overflow_nx = 1'b1;
        // Clamping keeps non-BCD digits within the worst-case latency.
        count_nx = (rhs_digit > 4'd9) ? 4'd9 : rhs_digit;
        if (rhs_digit == 4'd0) begin
          if (idx != 2'd0) idx_nx = idx - 2'd1;
          else             state_nx = DONE;
        end else begin
          state_nx = MUL_ADD;
        end
      end
      MUL_ADD: begin
        acc_nx   = add_s;
        count_nx = count - 4'd1;
        if (add_cob) overflow_nx = 1'b1;
        if (count == 4'd1) begin
          if (idx != 2'd0) begin
            idx_nx   = idx - 2'd1;
            state_nx = MUL_SHIFT;
          end else begin
            state_nx = DONE;
          end
        end
      end
      MOD_TRY: begin
        // count tracks subtractions at this scale; a tenth try always advances.
        if (shifted_out || add_cob || count == 4'd9) begin
          count_nx = '0;
          if (idx == 2'd0) state_nx = DONE;
          else             idx_nx = idx - 2'd1;
        end else begin
          acc_nx   = add_s;
          count_nx = count + 4'd1;
        end
      end
      DONE: begin
        done_nx   = 1'b1;
        busy_nx   = 1'b0;
        result_nx = acc;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.negative    = negative_q;
  assign bus.overflow    = overflow_q;
  assign bus.div_by_zero = dbz_q;

endmodule
